morse_keyer: RTL and testbench

MORSE_KEYER -- requirements
Module: morse_keyer

---
 rtl/morse_pkg.sv | 46 ++++
 rtl/morse_unit_timer.sv | 79 +++++++
 rtl/morse_keyer.sv | 215 +++++++++++++++++++++
 tb/tb_morse_keyer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse keyer:
//   - FSM state encoding (IDLE, MARK, SPACE, GAP)
//   - Morse timing constants, expressed in units
//   - helpers that map a symbol or a gap type to its unit count
// -----------------------------------------------------------------------------
package morse_pkg;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_MARK  = 2'd1;
  localparam logic [STATE_W-1:0] ST_SPACE = 2'd2;
  localparam logic [STATE_W-1:0] ST_GAP   = 2'd3;

  // Wide enough for the longest segment (a word gap of 7 units).
  localparam int UNITS_W = 3;
  localparam logic [UNITS_W-1:0] DOT_UNITS      = 3'd1;
  localparam logic [UNITS_W-1:0] DASH_UNITS     = 3'd3;
  localparam logic [UNITS_W-1:0] SYM_GAP_UNITS  = 3'd1;
  localparam logic [UNITS_W-1:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [UNITS_W-1:0] WORD_GAP_UNITS = 3'd7;

  // Mark length in units for one symbol (0 = dot, 1 = dash).
  function automatic logic [UNITS_W-1:0] sym_units(input logic is_dash);
    logic [UNITS_W-1:0] units;
    if (is_dash) begin
      units = DASH_UNITS;
    end else begin
      units = DOT_UNITS;
    end
    return units;
  endfunction

  // Trailing gap in units after the last mark of a character.
  function automatic logic [UNITS_W-1:0] gap_units(input logic word_end);
    logic [UNITS_W-1:0] units;
    if (word_end) begin
      units = WORD_GAP_UNITS;
    end else begin
      units = CHAR_GAP_UNITS;
    end
    return units;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// -----------------------------------------------------------------------------
// morse_unit_timer
// Segment timer for the keyer. A prescaler produces a one-cycle unit tick every
// UNIT_CYCLES clocks; a unit counter, loaded with the segment length in units,
// counts those ticks down. o_Expired is high in the last clock of the segment,
// so a segment of N units lasts exactly N*UNIT_CYCLES clocks after the load.
//
// Ports:
//   i_Clock    rising-edge clock
//   i_Reset    synchronous active-high reset
//   i_Clear    stop the timer and zero both counters
//   i_Load     start a new segment of i_Units units (wins over a running count)
//   i_Units    segment length in units
//   o_Expired  high during the final clock of the loaded segment
// -----------------------------------------------------------------------------
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 6250000
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Clear,
  input  logic               i_Load,
  input  logic [UNITS_W-1:0] i_Units,
  output logic               o_Expired
);

  // The prescaler only ever runs to UNIT_CYCLES-1 and then restarts on the
  // tick, so whole segments are counted in units and nothing can overflow.
  localparam int CYC_W = $clog2(7 * UNIT_CYCLES);
  localparam logic [CYC_W-1:0]   CYC_ZERO   = CYC_W'(0);
  localparam logic [CYC_W-1:0]   CYC_ONE    = CYC_W'(1);
  localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(UNIT_CYCLES - 1);
  localparam logic [UNITS_W-1:0] UNITS_ZERO = UNITS_W'(0);
  localparam logic [UNITS_W-1:0] UNITS_ONE  = UNITS_W'(1);

  logic [CYC_W-1:0]   cyc_q,   cyc_d;
  logic [UNITS_W-1:0] units_q, units_d;
  logic               active_s;
  logic               tick_s;

  assign active_s  = (units_q != UNITS_ZERO);
  assign tick_s    = active_s && (cyc_q == CYC_LAST);
  assign o_Expired = tick_s && (units_q == UNITS_ONE);

  // Next-state logic for prescaler and unit down-counter.
  always_comb begin
    cyc_d   = cyc_q;
    units_d = units_q;
    if (i_Clear) begin
      cyc_d   = CYC_ZERO;
      units_d = UNITS_ZERO;
    end else if (i_Load) begin
      cyc_d   = CYC_ZERO;
      units_d = i_Units;
    end else if (tick_s) begin
      cyc_d   = CYC_ZERO;
      units_d = units_q - UNITS_ONE;
    end else if (active_s) begin
      cyc_d   = cyc_q + CYC_ONE;
    end else begin
      cyc_d   = cyc_q;
      units_d = units_q;
    end
  end

  // Counter registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cyc_q   <= CYC_ZERO;
      units_q <= UNITS_ZERO;
    end else begin
      cyc_q   <= cyc_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// -----------------------------------------------------------------------------
// morse_keyer
// Keys one Morse character per request onto o_LED. A character is a pattern of
// up to MAX_SYMBOLS dots/dashes (MSB first, 1 = dash) followed by a character
// gap (3 units) or a word gap (7 units).
//
// Ports:
//   i_Clock     rising-edge clock
//   i_Reset     synchronous active-high reset
//   i_Valid     character request, taken when i_Valid && o_Ready
//   i_Pattern   symbols, MSB first, 0 = dot, 1 = dash
//   i_Length    number of symbols (clamped to MAX_SYMBOLS)
//   i_Word_End  1 = trailing word gap, 0 = trailing character gap
//   i_Abort     drop the current character at once, no completion pulse
//   o_Ready     high in IDLE
//   o_LED       keyed output, 1 = mark
//   o_Busy      high outside IDLE
//   o_Done      one-cycle pulse when a character (with its gap) completes
// -----------------------------------------------------------------------------
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 6250000,
  parameter int MAX_SYMBOLS = 8,
  parameter int LEN_W       = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Valid,
  input  logic [MAX_SYMBOLS-1:0] i_Pattern,
  input  logic [LEN_W-1:0]       i_Length,
  input  logic                   i_Word_End,
  input  logic                   i_Abort,
  output logic                   o_Ready,
  output logic                   o_LED,
  output logic                   o_Busy,
  output logic                   o_Done
);

  // One extra bit so the index can reach L == MAX_SYMBOLS without wrapping.
  localparam int IDX_W = $clog2(MAX_SYMBOLS) + 1;
  localparam logic [IDX_W-1:0]       IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1);
  localparam logic [LEN_W-1:0]       LEN_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0]       LEN_MAX  = LEN_W'(MAX_SYMBOLS);
  localparam logic [MAX_SYMBOLS-1:0] PAT_ZERO = MAX_SYMBOLS'(0);

  logic [STATE_W-1:0]     state_q, state_d;
  logic [MAX_SYMBOLS-1:0] pat_q,   pat_d;
  logic [LEN_W-1:0]       len_q,   len_d;
  logic                   word_q,  word_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic                   led_q,   led_d;
  logic                   busy_q,  busy_d;
  logic                   ready_q, ready_d;
  logic                   done_q,  done_d;

  logic [LEN_W-1:0]   len_clamp_s;
  logic [IDX_W-1:0]   idx_next_s;
  logic               tmr_clear_s;
  logic               tmr_load_s;
  logic [UNITS_W-1:0] tmr_units_s;
  logic               tmr_expired_s;

  assign idx_next_s = idx_q + IDX_ONE;

  assign o_Ready = ready_q;
  assign o_LED   = led_q;
  assign o_Busy  = busy_q;
  assign o_Done  = done_q;

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_timer (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Clear   (tmr_clear_s),
    .i_Load    (tmr_load_s),
    .i_Units   (tmr_units_s),
    .o_Expired (tmr_expired_s)
  );

  // Clamp the requested length to the pattern width.
  always_comb begin
    if (i_Length > LEN_MAX) begin
      len_clamp_s = LEN_MAX;
    end else begin
      len_clamp_s = i_Length;
    end
  end

  // FSM next state, symbol bookkeeping and timer control.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    word_d      = word_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    tmr_clear_s = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_units_s = UNITS_W'(0);
    case (state_q)
      ST_IDLE: begin
        // i_Abort is ignored here so it cannot block a transfer.
        if (i_Valid) begin
          pat_d  = i_Pattern;
          len_d  = len_clamp_s;
          word_d = i_Word_End;
          idx_d  = IDX_ZERO;
          if (len_clamp_s != LEN_ZERO) begin
            state_d     = ST_MARK;
            tmr_load_s  = 1'b1;
            tmr_units_s = sym_units(i_Pattern[MAX_SYMBOLS-1]);
          end else if (i_Word_End) begin
            state_d     = ST_GAP;
            tmr_load_s  = 1'b1;
            tmr_units_s = WORD_GAP_UNITS;
          end else begin
            // Empty character without a word gap completes immediately.
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MARK: begin
        if (i_Abort) begin
          state_d     = ST_IDLE;
          idx_d       = IDX_ZERO;
          tmr_clear_s = 1'b1;
        end else if (tmr_expired_s) begin
          tmr_load_s = 1'b1;
          if (idx_next_s == IDX_W'(len_q)) begin
            // The trailing gap already includes the inter-symbol space.
            state_d     = ST_GAP;
            tmr_units_s = gap_units(word_q);
          end else begin
            // Shift so the next symbol sits in the MSB for the SPACE->MARK step.
            state_d     = ST_SPACE;
            tmr_units_s = SYM_GAP_UNITS;
            idx_d       = idx_next_s;
            pat_d       = pat_q << 1;
          end
        end else begin
          state_d = ST_MARK;
        end
      end
      ST_SPACE: begin
        if (i_Abort) begin
          state_d     = ST_IDLE;
          idx_d       = IDX_ZERO;
          tmr_clear_s = 1'b1;
        end else if (tmr_expired_s) begin
          state_d     = ST_MARK;
          tmr_load_s  = 1'b1;
          tmr_units_s = sym_units(pat_q[MAX_SYMBOLS-1]);
        end else begin
          state_d = ST_SPACE;
        end
      end
      ST_GAP: begin
        if (i_Abort) begin
          state_d     = ST_IDLE;
          idx_d       = IDX_ZERO;
          tmr_clear_s = 1'b1;
        end else if (tmr_expired_s) begin
          state_d = ST_IDLE;
          idx_d   = IDX_ZERO;
          done_d  = 1'b1;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        idx_d       = IDX_ZERO;
        tmr_clear_s = 1'b1;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered.
  always_comb begin
    led_d   = (state_d == ST_MARK);
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      pat_q   <= PAT_ZERO;
      len_q   <= LEN_ZERO;
      word_q  <= 1'b0;
      idx_q   <= IDX_ZERO;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// -----------------------------------------------------------------------------
// tb_morse_keyer
// Table-driven bench for morse_keyer with UNIT_CYCLES=4, MAX_SYMBOLS=8.
// Each table record drives its inputs for one clock edge and then expects
// constant outputs {LED, Busy, Ready, Done} for n consecutive cycles.
// -----------------------------------------------------------------------------
module tb_morse_keyer;

  localparam int UC = 4;
  localparam int MS = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_Valid = 1'b0;
  logic [MS-1:0] i_Pattern = 8'h00;
  logic [LW-1:0] i_Length = 4'd0;
  logic          i_Word_End = 1'b0;
  logic          i_Abort = 1'b0;
  logic          o_Ready;
  logic          o_LED;
  logic          o_Busy;
  logic          o_Done;

  morse_keyer #(
    .UNIT_CYCLES (UC),
    .MAX_SYMBOLS (MS),
    .LEN_W       (LW)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (i_Reset),
    .i_Valid    (i_Valid),
    .i_Pattern  (i_Pattern),
    .i_Length   (i_Length),
    .i_Word_End (i_Word_End),
    .i_Abort    (i_Abort),
    .o_Ready    (o_Ready),
    .o_LED      (o_LED),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done)
  );

  always #5 clk = ~clk;

  // Output codes {LED, Busy, Ready, Done}
  localparam logic [3:0] O_MARK = 4'b1100;
  localparam logic [3:0] O_OFF  = 4'b0100;
  localparam logic [3:0] O_DONE = 4'b0011;
  localparam logic [3:0] O_IDLE = 4'b0010;

  typedef struct {
    logic       rst;
    logic       valid;
    logic       abort;
    logic       word_end;
    logic [7:0] pattern;
    logic [3:0] length;
    int         n;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic void add_in(input logic rst, input logic valid, input logic abort,
                                 input logic word_end, input logic [7:0] pattern,
                                 input logic [3:0] length, input int n,
                                 input logic [3:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.valid = valid; v.abort = abort; v.word_end = word_end;
    v.pattern = pattern; v.length = length; v.n = n; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  function automatic void add_hold(input int n, input logic [3:0] exp, input string name);
    add_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, n, exp, name);
  endfunction

  initial begin
    logic [3:0] got;
    int busy_cnt;
    int done_cnt;
    int led_cnt;

    // reset state
    add_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 2, O_IDLE, "reset");
    add_hold(2, O_IDLE, "idle");
    // "A": dot, dash, character gap; done on cycle 33
    add_in(1'b0, 1'b1, 1'b0, 1'b0, 8'b0100_0000, 4'd2, 4, O_MARK, "A_dot");
    add_hold(4, O_OFF, "A_space");
    add_hold(12, O_MARK, "A_dash");
    add_hold(12, O_OFF, "A_gap");
    add_hold(1, O_DONE, "A_done");
    add_hold(2, O_IDLE, "A_after");
    // "E" with word gap, then "T" accepted on the done cycle
    add_in(1'b0, 1'b1, 1'b0, 1'b1, 8'b0000_0000, 4'd1, 4, O_MARK, "E_dot");
    add_hold(28, O_OFF, "E_wordgap");
    add_hold(1, O_DONE, "E_done");
    add_in(1'b0, 1'b1, 1'b0, 1'b0, 8'b1000_0000, 4'd1, 12, O_MARK, "T_b2b_dash");
    add_hold(12, O_OFF, "T_gap");
    add_hold(1, O_DONE, "T_done");
    add_hold(2, O_IDLE, "T_after");
    // empty characters
    add_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 28, O_OFF, "L0_word_gap");
    add_hold(1, O_DONE, "L0_word_done");
    add_hold(1, O_IDLE, "L0_word_after");
    add_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1, O_DONE, "L0_char_done");
    add_hold(1, O_IDLE, "L0_char_after");
    // abort on cycle 6 of a dash, then "E"
    add_in(1'b0, 1'b1, 1'b0, 1'b0, 8'b1000_0000, 4'd1, 6, O_MARK, "abort_dash");
    add_in(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 4, O_IDLE, "abort_idle");
    add_in(1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_0000, 4'd1, 4, O_MARK, "postabort_E");
    add_hold(12, O_OFF, "postabort_gap");
    add_hold(1, O_DONE, "postabort_done");
    add_hold(1, O_IDLE, "postabort_after");
    // abort in IDLE does not block a transfer
    add_in(1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0000, 4'd1, 4, O_MARK, "idleabort_E");
    add_hold(12, O_OFF, "idleabort_gap");
    add_hold(1, O_DONE, "idleabort_done");
    add_hold(1, O_IDLE, "idleabort_after");
    // reset mid-SPACE of "A"
    add_in(1'b0, 1'b1, 1'b0, 1'b0, 8'b0100_0000, 4'd2, 4, O_MARK, "rstA_dot");
    add_hold(2, O_OFF, "rstA_space");
    add_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1, O_IDLE, "rst_midspace");
    add_hold(2, O_IDLE, "rst_after");
    // reset wins over a simultaneous request
    add_in(1'b1, 1'b1, 1'b0, 1'b0, 8'b1000_0000, 4'd1, 1, O_IDLE, "rst_vs_valid");
    add_hold(2, O_IDLE, "rst_vs_valid_after");
    // L=12 clamps to 8 dots
    add_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd12, 4, O_MARK, "clamp_dot0");
    for (int s = 1; s < 8; s++) begin
      add_hold(4, O_OFF, "clamp_space");
      add_hold(4, O_MARK, "clamp_dot");
    end
    add_hold(12, O_OFF, "clamp_gap");
    add_hold(1, O_DONE, "clamp_done");
    add_hold(2, O_IDLE, "clamp_after");

    for (int i = 0; i < vecs.size(); i++) begin
      i_Reset    = vecs[i].rst;
      i_Valid    = vecs[i].valid;
      i_Abort    = vecs[i].abort;
      i_Word_End = vecs[i].word_end;
      i_Pattern  = vecs[i].pattern;
      i_Length   = vecs[i].length;
      for (int k = 0; k < vecs[i].n; k++) begin
        @(posedge clk);
        #1;
        i_Reset = 1'b0;
        i_Valid = 1'b0;
        i_Abort = 1'b0;
        got = {o_LED, o_Busy, o_Ready, o_Done};
        n_cmp++;
        if (got !== vecs[i].exp) begin
          n_err++;
          $display("FAIL %s (vec %0d cycle %0d): led/busy/ready/done got %b required %b",
                   vecs[i].name, i, k + 1, got, vecs[i].exp);
        end
      end
    end

    // Hand-written window: empty word character, count busy cycles and done pulses.
    busy_cnt = 0;
    done_cnt = 0;
    led_cnt  = 0;
    i_Valid    = 1'b1;
    i_Length   = 4'd0;
    i_Word_End = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      i_Valid = 1'b0;
      if (o_Busy) busy_cnt++;
      if (o_Done) done_cnt++;
      if (o_LED)  led_cnt++;
    end
    n_cmp++;
    if (busy_cnt != 28) begin
      n_err++;
      $display("FAIL L0_busy_count: got %0d required 28", busy_cnt);
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL L0_done_count: got %0d required 1", done_cnt);
    end
    n_cmp++;
    if (led_cnt != 0) begin
      n_err++;
      $display("FAIL L0_led_count: got %0d required 0", led_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
